// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line, a single
// outstanding fill to memctrl, registered outputs.
module icache #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned ADDR_USED  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_get,
  input  logic [31:0] if_address,
  output logic        if_done,
  output logic [31:0] if_inst,
  output logic        mem_get,
  output logic [31:0] mem_address,
  input  logic        mem_done,
  input  logic [31:0] mem_inst
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = ADDR_USED - INDEX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

  state_e                state_q;
  logic [Lines-1:0]      valid_q;
  logic [TagBits-1:0]    tag_q  [Lines];
  logic [31:0]           data_q [Lines];
  logic [31:2]           miss_pc_q;
  logic                  if_done_q;
  logic [31:0]           if_inst_q;
  logic                  mem_get_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TagBits-1:0]    req_tag;
  logic [TagBits-1:0]    miss_tag;
  logic                  hit;
  logic                  fill;
  logic                  pc_match;
  logic                  unused_addr_bits;

  assign req_index  = if_address[INDEX_BITS+1:2];
  assign req_tag    = if_address[ADDR_USED-1:INDEX_BITS+2];
  assign miss_index = miss_pc_q[INDEX_BITS+1:2];
  assign miss_tag   = miss_pc_q[ADDR_USED-1:INDEX_BITS+2];
  assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign pc_match   = if_get && (if_address[31:2] == miss_pc_q);
  // Reset and a frozen pipeline both discard a returning fill.
  assign fill       = rdy_in && !rst_in && (state_q == StMiss) && mem_done;

  assign unused_addr_bits = ^if_address[1:0];

  assign if_done     = if_done_q;
  assign if_inst     = if_inst_q;
  assign mem_get     = mem_get_q;
  assign mem_address = {miss_pc_q, 2'b00};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      miss_pc_q <= '0;
      if_done_q <= 1'b0;
      if_inst_q <= '0;
      mem_get_q <= 1'b0;
    end else if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if_done_q <= 1'b0;
          if (if_get) begin
            if (hit) begin
              if_done_q <= 1'b1;
              if_inst_q <= data_q[req_index];
              state_q   <= StResp;
            end else begin
              mem_get_q <= 1'b1;
              miss_pc_q <= if_address[31:2];
              state_q   <= StMiss;
            end
          end
        end
        StMiss: begin
          if (mem_done) begin
            mem_get_q           <= 1'b0;
            valid_q[miss_index] <= 1'b1;
            // A redirected fetch still commits the fill but gets no response.
            if (pc_match) begin
              if_done_q <= 1'b1;
              if_inst_q <= mem_inst;
              state_q   <= StResp;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StResp: begin
          if_done_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      data_q[miss_index] <= mem_inst;
      tag_q[miss_index]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected instruction words are queued when a fetch
// is issued and popped when if_done pulses; memctrl is modelled inline.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_get;
  logic [31:0] if_address;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_get;
  logic [31:0] mem_address;
  logic        mem_done;
  logic [31:0] mem_inst;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  icache #(.INDEX_BITS(8), .ADDR_USED(18)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .if_get      (if_get),
    .if_address  (if_address),
    .if_done     (if_done),
    .if_inst     (if_inst),
    .mem_get     (mem_get),
    .mem_address (mem_address),
    .mem_done    (mem_done),
    .mem_inst    (mem_inst)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One complete fetch; for a miss memctrl answers after lat cycles with fill.
  task automatic do_fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] fill,
                          input int lat, input logic [31:0] exp_inst, input string name);
    logic [31:0] want;
    if_get     = 1'b1;
    if_address = addr;
    exp_q.push_back(exp_inst);
    tick();
    if (exp_hit) begin
      checks++;
      if (if_done !== 1'b1) $display("FAIL %s hit_latency: if_done=%b want 1", name, if_done);
      else passed++;
      checks++;
      if (mem_get !== 1'b0) $display("FAIL %s hit_no_mem: mem_get=%b want 0", name, mem_get);
      else passed++;
    end else begin
      checks++;
      if (mem_get !== 1'b1 || mem_address !== {addr[31:2], 2'b00} || if_done !== 1'b0)
        $display("FAIL %s miss_req: mem_get=%b addr=%h done=%b want 1 %h 0", name, mem_get,
                 mem_address, if_done, {addr[31:2], 2'b00});
      else passed++;
      repeat (lat) tick();
      checks++;
      if (mem_get !== 1'b1 || mem_address !== {addr[31:2], 2'b00} || if_done !== 1'b0)
        $display("FAIL %s miss_hold: mem_get=%b addr=%h done=%b want 1 %h 0", name, mem_get,
                 mem_address, if_done, {addr[31:2], 2'b00});
      else passed++;
      mem_done = 1'b1;
      mem_inst = fill;
      tick();
      mem_done = 1'b0;
      mem_inst = 32'h0;
      checks++;
      if (if_done !== 1'b1 || mem_get !== 1'b0)
        $display("FAIL %s miss_done: if_done=%b mem_get=%b want 1 0", name, if_done, mem_get);
      else passed++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: queue empty, got if_inst=%h", name, if_inst);
    end else begin
      want = exp_q.pop_front();
      if (if_inst !== want) $display("FAIL %s inst: got %h want %h", name, if_inst, want);
      else passed++;
    end
    if_get = 1'b0;
    tick();
    checks++;
    if (if_done !== 1'b0) $display("FAIL %s pulse_width: if_done=%b want 0", name, if_done);
    else passed++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; if_get = 1'b0; if_address = '0;
    mem_done = 1'b0; mem_inst = '0;
    tick(); tick();
    rst_in = 1'b0;
    checks++;
    if (if_done !== 1'b0 || if_inst !== 32'h0 || mem_get !== 1'b0 || mem_address !== 32'h0)
      $display("FAIL reset_state: done=%b inst=%h get=%b addr=%h want 0 0 0 0", if_done,
               if_inst, mem_get, mem_address);
    else passed++;
  endtask

  task automatic test_cold_miss_and_hit();
    do_fetch(32'h0000_1000, 1'b0, 32'h0000_0013, 4, 32'h0000_0013, "cold_miss");
    do_fetch(32'h0000_1000, 1'b1, 32'h0, 0, 32'h0000_0013, "hit");
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_1400, 1'b0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, "conflict_fill");
    do_fetch(32'h0000_1400, 1'b1, 32'h0, 0, 32'hDEAD_BEEF, "conflict_hit");
    do_fetch(32'h0000_1000, 1'b0, 32'h0000_0013, 3, 32'h0000_0013, "conflict_refill");
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0000_1004, 1'b0, 32'hA5A5_0001, 1, 32'hA5A5_0001, "b2b_fill");
    do_fetch(32'h0000_1000, 1'b1, 32'h0, 0, 32'h0000_0013, "b2b_hit0");
    do_fetch(32'h0000_1006, 1'b1, 32'h0, 0, 32'hA5A5_0001, "b2b_hit1");
    // Held if_get through the response cycle must not retrigger.
    if_get = 1'b1; if_address = 32'h0000_1004;
    tick();
    checks++;
    if (if_done !== 1'b1 || if_inst !== 32'hA5A5_0001)
      $display("FAIL held_hit: done=%b inst=%h want 1 a5a50001", if_done, if_inst);
    else passed++;
    tick();
    checks++;
    if (if_done !== 1'b0) $display("FAIL held_no_double: if_done=%b want 0", if_done);
    else passed++;
    if_get = 1'b0;
    tick();
  endtask

  task automatic test_redirect();
    if_get = 1'b1; if_address = 32'h0000_2000;
    tick();
    checks++;
    if (mem_get !== 1'b1 || mem_address !== 32'h0000_2000)
      $display("FAIL redirect_req: mem_get=%b addr=%h want 1 00002000", mem_get, mem_address);
    else passed++;
    tick();
    if_address = 32'h0000_3000;
    tick();
    mem_done = 1'b1; mem_inst = 32'h2222_2222;
    tick();
    mem_done = 1'b0; mem_inst = '0; if_get = 1'b0;
    checks++;
    if (if_done !== 1'b0 || mem_get !== 1'b0)
      $display("FAIL redirect_no_done: done=%b get=%b want 0 0", if_done, mem_get);
    else passed++;
    tick();
    checks++;
    if (if_done !== 1'b0) $display("FAIL redirect_quiet: if_done=%b want 0", if_done);
    else passed++;
    do_fetch(32'h0000_2000, 1'b1, 32'h0, 0, 32'h2222_2222, "redirect_hit");
    do_fetch(32'h0000_3000, 1'b0, 32'h3333_3333, 2, 32'h3333_3333, "redirect_miss");
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] want;
    if_get = 1'b1; if_address = 32'h0000_4000;
    exp_q.push_back(32'h4444_4444);
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_get !== 1'b1 || mem_address !== 32'h0000_4000 || if_done !== 1'b0 ||
          if_inst !== 32'h3333_3333)
        $display("FAIL freeze_miss%0d: get=%b addr=%h done=%b inst=%h want 1 4000 0 33333333",
                 i, mem_get, mem_address, if_done, if_inst);
      else passed++;
    end
    rdy_in = 1'b1;
    tick();
    mem_done = 1'b1; mem_inst = 32'h4444_4444;
    tick();
    mem_done = 1'b0; mem_inst = '0; if_get = 1'b0;
    checks++;
    if (if_done !== 1'b1 || mem_get !== 1'b0)
      $display("FAIL freeze_done: done=%b get=%b want 1 0", if_done, mem_get);
    else passed++;
    // Freeze in the response cycle holds the pulse high.
    rdy_in = 1'b0;
    tick(); tick();
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL freeze_scoreboard: queue empty, got if_inst=%h", if_inst);
    end else begin
      want = exp_q.pop_front();
      if (if_done !== 1'b1 || if_inst !== want)
        $display("FAIL freeze_resp: done=%b inst=%h want 1 %h", if_done, if_inst, want);
      else passed++;
    end
    rdy_in = 1'b1;
    tick();
    checks++;
    if (if_done !== 1'b0) $display("FAIL freeze_release: if_done=%b want 0", if_done);
    else passed++;
  endtask

  task automatic test_reset_mid_miss();
    if_get = 1'b1; if_address = 32'h0000_5000;
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; if_get = 1'b0;
    checks++;
    if (mem_get !== 1'b0 || if_done !== 1'b0 || mem_address !== 32'h0 || if_inst !== 32'h0)
      $display("FAIL rst_mid_miss: get=%b done=%b addr=%h inst=%h want 0 0 0 0", mem_get,
               if_done, mem_address, if_inst);
    else passed++;
    mem_done = 1'b1; mem_inst = 32'h5555_5555;
    tick();
    mem_done = 1'b0; mem_inst = '0;
    checks++;
    if (if_done !== 1'b0 || mem_get !== 1'b0)
      $display("FAIL stale_mem_done: done=%b get=%b want 0 0", if_done, mem_get);
    else passed++;
    // Reset coinciding with mem_done must discard the fill.
    if_get = 1'b1; if_address = 32'h0000_5000;
    tick();
    rst_in = 1'b1; mem_done = 1'b1; mem_inst = 32'h5555_5555;
    tick();
    rst_in = 1'b0; mem_done = 1'b0; mem_inst = '0; if_get = 1'b0;
    tick();
    do_fetch(32'h0000_5000, 1'b0, 32'h5050_5050, 1, 32'h5050_5050, "rst_fill_dropped");
    do_fetch(32'h0000_2000, 1'b0, 32'h2020_2020, 2, 32'h2020_2020, "rst_cleared_valid");
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_back_to_back();
    test_redirect();
    test_rdy_freeze();
    test_reset_mid_miss();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
